// File: rtl/m216a_dsm_decoder_if.sv
// ============================================================================
// m216a_dsm_decoder_if : sample/handshake/result bundle for the DSM decoder
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface m216a_dsm_decoder_if;
  logic [3:0]  dsm_in;
  logic        start;
  logic        busy;
  logic        valid;
  logic [3:0]  avg_i;
  logic [15:0] avg_f;
  logic        range_err;

  modport master (
    output dsm_in, start,
    input  busy, valid, avg_i, avg_f, range_err
  );

  modport slave (
    input  dsm_in, start,
    output busy, valid, avg_i, avg_f, range_err
  );
endinterface

`default_nettype wire

// File: rtl/m216a_dsm_decoder.sv
// ============================================================================
// m216a_dsm_decoder : window-mean of the DSM output stream (4.16 result)
// Optional range check built when M216A_DEC_RANGE_CHK_EN is defined.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module m216a_dsm_decoder #(
  parameter int WIN_LOG2 = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  m216a_dsm_decoder_if.slave    dec_if
);

  localparam int ACC_W = WIN_LOG2 + 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q;
  logic [ACC_W-1:0]    acc_q;
  logic [WIN_LOG2-1:0] cnt_q;
  logic                busy_q;
  logic                valid_q;
  logic [3:0]          avg_i_q;
  logic [15:0]         avg_f_q;
  logic                range_err_q;

  logic [ACC_W-1:0]    acc_d;
  logic [15:0]         frac_d;
  logic                oor_d;

  // Sum including the current sample, so the last sample lands in the result.
  assign acc_d = acc_q + {{WIN_LOG2{1'b0}}, dec_if.dsm_in};

  generate
    if (WIN_LOG2 >= 16) begin : g_frac_trunc
      assign frac_d = acc_d[WIN_LOG2-1 -: 16];
    end else begin : g_frac_pad
      assign frac_d = {acc_d[WIN_LOG2-1:0], {(16-WIN_LOG2){1'b0}}};
    end
  endgenerate

`ifdef M216A_DEC_RANGE_CHK_EN
  assign oor_d = (dec_if.dsm_in < 4'd5) || (dec_if.dsm_in > 4'd12);
`else
  assign oor_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      avg_i_q     <= '0;
      avg_f_q     <= '0;
      range_err_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_ACCUM: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (oor_d) begin
            range_err_q <= 1'b1;
          end
          if (&cnt_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            avg_i_q <= acc_d[WIN_LOG2+3:WIN_LOG2];
            avg_f_q <= frac_d;
          end
        end
        default: begin
          // IDLE and DONE share the start behaviour; DONE never lingers.
          if (dec_if.start) begin
            state_q     <= S_ACCUM;
            busy_q      <= 1'b1;
            acc_q       <= '0;
            cnt_q       <= '0;
            range_err_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign dec_if.busy      = busy_q;
  assign dec_if.valid     = valid_q;
  assign dec_if.avg_i     = avg_i_q;
  assign dec_if.avg_f     = avg_f_q;
  assign dec_if.range_err = range_err_q;

endmodule

`default_nettype wire

// File: tb/tb_m216a_dsm_decoder.sv
// ============================================================================
// tb_m216a_dsm_decoder : directed self-checking bench, WIN_LOG2 = 4
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_m216a_dsm_decoder;

  localparam int WIN = 4;

`ifdef M216A_DEC_RANGE_CHK_EN
  localparam logic RC_EXP = 1'b1;
`else
  localparam logic RC_EXP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [3:0] samp [16];

  m216a_dsm_decoder_if dif ();

  m216a_dsm_decoder #(.WIN_LOG2(WIN)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .dec_if (dif)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // start accepted at edge k; sample i is presented for edge k+1+i.
  task automatic run_window(input string tag, input logic [3:0] exp_i,
                            input logic [15:0] exp_f, input logic exp_err,
                            input int restart_at);
    int early;
    early = 0;
    @(negedge clk);
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    check({tag, "_busy"}, 32'(dif.busy), 32'd1);
    check({tag, "_errclr"}, 32'(dif.range_err), 32'd0);
    for (int i = 0; i < 16; i++) begin
      dif.dsm_in = samp[i];
      dif.start  = (i == restart_at);
      if (dif.valid) early++;
      @(negedge clk);
    end
    dif.start  = 1'b0;
    dif.dsm_in = 4'd8;
    check({tag, "_early"}, 32'(early), 32'd0);
    check({tag, "_valid"}, 32'(dif.valid), 32'd1);
    check({tag, "_busy0"}, 32'(dif.busy), 32'd0);
    check({tag, "_avg_i"}, 32'(dif.avg_i), 32'(exp_i));
    check({tag, "_avg_f"}, 32'(dif.avg_f), 32'(exp_f));
    check({tag, "_err"}, 32'(dif.range_err), 32'(exp_err));
    @(negedge clk);
    check({tag, "_vpulse"}, 32'(dif.valid), 32'd0);
    check({tag, "_hold_i"}, 32'(dif.avg_i), 32'(exp_i));
  endtask

  initial begin
    int nv;
    int busy_bad;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    dif.start  = 1'b0;
    dif.dsm_in = 4'd8;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(dif.busy), 32'd0);
    check("rst_valid", 32'(dif.valid), 32'd0);
    check("rst_avg_i", 32'(dif.avg_i), 32'd0);
    check("rst_avg_f", 32'(dif.avg_f), 32'd0);
    check("rst_err",   32'(dif.range_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 16; i++) samp[i] = 4'd7;
    run_window("const7", 4'd7, 16'h0000, 1'b0, -1);

    for (int i = 0; i < 16; i++) samp[i] = (i % 2 == 0) ? 4'd7 : 4'd8;
    run_window("alt78", 4'd7, 16'h8000, 1'b0, -1);

    for (int i = 0; i < 16; i++) samp[i] = (i < 4) ? 4'd12 : 4'd5;
    run_window("12x4_5x12", 4'd6, 16'hC000, 1'b0, -1);

    for (int i = 0; i < 16; i++) samp[i] = (i == 6) ? 4'd4 : 4'd8;
    run_window("oor4", 4'd7, 16'hC000, RC_EXP, -1);

    // Second start 5 cycles in must not restart; range_err from oor4 clears.
    for (int i = 0; i < 16; i++) samp[i] = (i % 4 == 0) ? 4'd10 : 4'd9;
    run_window("restart", 4'd9, 16'h4000, 1'b0, 4);

    // Partial window killed by reset at sample 9.
    @(negedge clk);
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      dif.dsm_in = (i == 2) ? 4'd13 : 4'd8;
      @(negedge clk);
    end
    check("pre_rst_err", 32'(dif.range_err), 32'(RC_EXP));
    rst_n = 1'b0;
    #0.2;
    check("arst_busy",  32'(dif.busy), 32'd0);
    check("arst_valid", 32'(dif.valid), 32'd0);
    check("arst_avg_i", 32'(dif.avg_i), 32'd0);
    check("arst_avg_f", 32'(dif.avg_f), 32'd0);
    check("arst_err",   32'(dif.range_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dif.valid || dif.busy) nv++;
    end
    check("arst_noact", 32'(nv), 32'd0);

    // Start held high: DONE -> ACCUM directly, one window per 17 cycles.
    dif.dsm_in = 4'd9;
    @(negedge clk);
    dif.start = 1'b1;
    nv = 0;
    busy_bad = 0;
    for (int j = 0; j < 52; j++) begin
      @(negedge clk);
      if (dif.valid) begin
        nv++;
        check("hold_pos",   32'(j % 17), 32'd16);
        check("hold_avg_i", 32'(dif.avg_i), 32'd9);
        check("hold_avg_f", 32'(dif.avg_f), 32'd0);
      end
      if (dif.busy == dif.valid) busy_bad++;
    end
    dif.start = 1'b0;
    check("hold_count", 32'(nv), 32'd3);
    check("hold_busy",  32'(busy_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
